// File: rtl/phase_accumulator.sv
// NCO phase accumulator feeding a dual-port sine ROM, with increment updates deferred to a phase wrap.
// Optional synchronous phase clear is enabled by defining PHASE_ACC_CLR_EN.
module phase_accumulator #(
  parameter int unsigned ACC_WIDTH     = 16,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned INCR_RESET    = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [ACC_WIDTH-1:0]     incr_in,
  input  logic                     incr_load,
  output logic                     incr_ack,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic [ADDRESS_WIDTH-1:0] addr1,
  output logic [ADDRESS_WIDTH-1:0] addr2,
`ifdef PHASE_ACC_CLR_EN
  input  logic                     clr,
`endif
  output logic                     wrap
);

  localparam logic [ACC_WIDTH-1:0] IncrReset = ACC_WIDTH'(INCR_RESET);

  typedef enum logic [1:0] {
    StIdle,
    StPending,
    StApply
  } state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] incr_q;
  logic [ACC_WIDTH-1:0] pend_q;
  logic                 wrap_q;
  logic                 ack_q;

  logic [ACC_WIDTH:0]   sum;
  logic                 advance;
  logic                 carry;

  assign sum = {1'b0, acc_q} + {1'b0, incr_q};

`ifdef PHASE_ACC_CLR_EN
  assign advance = en & ~clr;
`else
  assign advance = en;
`endif

  // Only a real add (not a clear, not a stall) may trigger a pending increment switch.
  assign carry = advance & sum[ACC_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      incr_q  <= IncrReset;
      pend_q  <= '0;
      wrap_q  <= 1'b0;
      ack_q   <= 1'b0;
      state_q <= StIdle;
    end else begin
      ack_q <= 1'b0;

      if (advance) begin
        acc_q  <= sum[ACC_WIDTH-1:0];
        wrap_q <= sum[ACC_WIDTH];
      end else begin
        wrap_q <= 1'b0;
`ifdef PHASE_ACC_CLR_EN
        if (clr) begin
          acc_q <= '0;
        end
`endif
      end

      case (state_q)
        StIdle: begin
          if (incr_load) begin
            pend_q <= incr_in;
            // A zero increment never wraps, so the new value is taken immediately.
            if (incr_q == '0) begin
              incr_q  <= incr_in;
              state_q <= StApply;
            end else begin
              state_q <= StPending;
            end
          end
        end
        StPending: begin
          if (incr_load) begin
            pend_q <= incr_in;
          end
          if (carry) begin
            incr_q  <= incr_load ? incr_in : pend_q;
            state_q <= StApply;
          end
        end
        StApply: begin
          ack_q <= 1'b1;
          if (incr_load) begin
            pend_q  <= incr_in;
            state_q <= StPending;
          end else begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign addr1    = acc_q[ACC_WIDTH-1 -: ADDRESS_WIDTH];
  assign addr2    = addr1 + offset;
  assign wrap     = wrap_q;
  assign incr_ack = ack_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed bench for phase_accumulator: counting, offset address, deferred increment updates,
// asynchronous reset while pending, stall, and (with PHASE_ACC_CLR_EN) phase clear.
module tb_phase_accumulator;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] incr_in;
  logic        incr_load;
  logic        incr_ack;
  logic [7:0]  offset;
  logic [7:0]  addr1;
  logic [7:0]  addr2;
  logic        wrap;
`ifdef PHASE_ACC_CLR_EN
  logic        clr;
`endif

  int tests_run;
  int tests_failed;

  phase_accumulator #(
    .ACC_WIDTH    (16),
    .ADDRESS_WIDTH(8),
    .INCR_RESET   (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .incr_in  (incr_in),
    .incr_load(incr_load),
    .incr_ack (incr_ack),
    .offset   (offset),
    .addr1    (addr1),
    .addr2    (addr2),
`ifdef PHASE_ACC_CLR_EN
    .clr      (clr),
`endif
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until wrap is seen (bounded); no ack may appear while waiting.
  task automatic run_to_wrap(input string tag);
    int  n    = 0;
    bit  seen = 1'b0;
    int  acks = 0;
    while (!seen && n < 400) begin
      step();
      n++;
      if (wrap) seen = 1'b1;
      if (incr_ack) acks++;
    end
    check({tag, "_wrap_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_no_early_ack"}, acks, 32'd0);
  endtask

  initial begin
    logic [7:0] exp8;
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    en        = 1'b0;
    incr_in   = '0;
    incr_load = 1'b0;
    offset    = 8'd64;
`ifdef PHASE_ACC_CLR_EN
    clr       = 1'b0;
`endif

    // Reset values
    #3;
    check("rst_addr1", addr1, 0);
    check("rst_addr2", addr2, 64);
    check("rst_wrap", wrap, 0);
    check("rst_ack", incr_ack, 0);

    // Scenario 1/2: free-running count with offset address
    step();
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step();
      exp8 = i[7:0];
      check("cnt_addr1", addr1, exp8);
      check("cnt_wrap", wrap, (i == 256) ? 1 : 0);
      exp8 = i[7:0] + 8'd64;
      check("cnt_addr2", addr2, exp8);
      if (i == 100) begin
        offset = 8'd200;
        #1;
        check("addr2_off200", addr2, 44);
        offset = 8'd64;
      end
    end

    // Scenario 3: move to acc=0x1000, then request incr=512
    for (int i = 1; i <= 16; i++) step();
    check("s3_start", addr1, 16);
    incr_in   = 16'd512;
    incr_load = 1'b1;
    step();
    incr_load = 1'b0;
    check("s3_load_edge", addr1, 17);
    for (int a = 18; a <= 255; a++) begin
      step();
      exp8 = a[7:0];
      check("s3_old_step", addr1, exp8);
      check("s3_no_ack", incr_ack, 0);
    end
    step();
    check("s3_wrap_addr", addr1, 0);
    check("s3_wrap", wrap, 1);
    check("s3_ack_not_yet", incr_ack, 0);
    step();
    check("s3_new_step", addr1, 2);
    check("s3_ack", incr_ack, 1);
    step();
    check("s3_step4", addr1, 4);
    check("s3_ack_once", incr_ack, 0);

    // Scenario 4: two loads before wrap, latest (700) wins
    incr_in   = 16'd300;
    incr_load = 1'b1;
    step();
    incr_load = 1'b0;
    step();
    incr_in   = 16'd700;
    incr_load = 1'b1;
    step();
    incr_load = 1'b0;
    check("s4_old_step", addr1, 8'h0a);
    run_to_wrap("s4");
    check("s4_wrap_addr", addr1, 0);
    step();
    check("s4_700_a", addr1, 8'h02);
    check("s4_ack", incr_ack, 1);
    step();
    check("s4_700_b", addr1, 8'h05);
    check("s4_ack_once", incr_ack, 0);

    // Scenario 5: reset while pending
    incr_in   = 16'd512;
    incr_load = 1'b1;
    step();
    incr_load = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("s5_rst_addr1", addr1, 0);
    check("s5_rst_addr2", addr2, 64);
    check("s5_rst_wrap", wrap, 0);
    check("s5_rst_ack", incr_ack, 0);
    step();
    rst = 1'b0;
    for (int i = 1; i <= 260; i++) begin
      step();
      exp8 = i[7:0];
      check("s5_addr1", addr1, exp8);
      check("s5_no_ack", incr_ack, 0);
      check("s5_wrap", wrap, (i == 256) ? 1 : 0);
    end

    // Scenario 4b: drive increment to zero, then load 256 without a wrap
    incr_in   = 16'd0;
    incr_load = 1'b1;
    step();
    incr_load = 1'b0;
    run_to_wrap("zero");
    step();
    check("zero_frozen", addr1, 0);
    check("zero_ack", incr_ack, 1);
    incr_in   = 16'd256;
    incr_load = 1'b1;
    step();
    incr_load = 1'b0;
    check("z256_addr_a", addr1, 0);
    check("z256_ack_lo", incr_ack, 0);
    step();
    check("z256_addr_b", addr1, 1);
    check("z256_ack", incr_ack, 1);
    step();
    check("z256_addr_c", addr1, 2);
    check("z256_ack_once", incr_ack, 0);

    // Scenario 6: stall
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_addr1", addr1, 2);
      check("stall_wrap", wrap, 0);
    end
    en = 1'b1;
    step();
    check("resume_addr1", addr1, 3);
    run_to_wrap("s6");
    en = 1'b0;
    step();
    check("stall_after_wrap", wrap, 0);
    check("stall_after_addr", addr1, 0);

`ifdef PHASE_ACC_CLR_EN
    en        = 1'b1;
    incr_in   = 16'd512;
    incr_load = 1'b1;
    step();
    incr_load = 1'b0;
    step();
    check("clr_pre", addr1, 2);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_addr1", addr1, 0);
    check("clr_wrap", wrap, 0);
    step();
    check("clr_resume", addr1, 1);
    run_to_wrap("clr");
    step();
    check("clr_pend_kept", addr1, 2);
    check("clr_ack", incr_ack, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
